// File: rtl/save_read_engine.sv
// rtl/save_read_engine.sv - burst read initiator for one image read port of the memory pool
//
// Takes a burst command (group, bank mask, base address, length) and issues one read
// request per word on the pool's addr/data handshake. Returned rows go into a small
// FIFO, and the rows stream out in request order with a last flag.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_*                       burst command (valid/ready handshake)
//   read_group_id_o, read_bank_en_o, read_addr_o, read_addr_ready_i
//                               request channel to the pool (request = bank_en != 0)
//   read_data_valid_i, read_data_i, read_data_ready_o
//                               returned rows from the pool
//   out_valid_o, out_data_o, out_last_o, out_ready_i
//                               row stream to the saver
//   done_o                      one-cycle pulse when a burst completes
module save_read_engine #(
  parameter int IMG_GRP_NUM     = 3,
  parameter int ROW_PARA        = 4,
  parameter int CHL_PARA        = 8,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int BANK_UNIT_WIDTH = 8,
  parameter int LEN_WIDTH       = 12,
  parameter int FIFO_DEPTH      = 4,
  parameter int IMG_ADDR_WIDTH  = ROW_PARA * BANK_ADDR_WIDTH,
  parameter int IMG_DATA_WIDTH  = ROW_PARA * CHL_PARA * BANK_UNIT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [IMG_GRP_NUM-1:0]     cmd_group_id_i,
  input  logic [ROW_PARA-1:0]        cmd_bank_en_i,
  input  logic [BANK_ADDR_WIDTH-1:0] cmd_base_addr_i,
  input  logic [LEN_WIDTH-1:0]       cmd_len_i,
  output logic [IMG_GRP_NUM-1:0]     read_group_id_o,
  output logic [ROW_PARA-1:0]        read_bank_en_o,
  output logic [IMG_ADDR_WIDTH-1:0]  read_addr_o,
  input  logic                       read_addr_ready_i,
  input  logic                       read_data_valid_i,
  input  logic [IMG_DATA_WIDTH-1:0]  read_data_i,
  output logic                       read_data_ready_o,
  output logic                       out_valid_o,
  output logic [IMG_DATA_WIDTH-1:0]  out_data_o,
  output logic                       out_last_o,
  input  logic                       out_ready_i,
  output logic                       done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t                     r_state;
  logic [IMG_GRP_NUM-1:0]     r_group;
  logic [ROW_PARA-1:0]        r_bank_en;
  logic [BANK_ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]       r_issue_cnt;
  logic [LEN_WIDTH-1:0]       r_recv_cnt;   // words not yet streamed out
  logic [CNT_W-1:0]           r_outstanding;
  logic [CNT_W-1:0]           r_fifo_cnt;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [IMG_DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];

  logic [CNT_W:0] w_inflight;
  logic           w_credit;
  logic           w_req;
  logic           w_req_fire;
  logic           w_full;
  logic           w_push;
  logic           w_pop;

  // Every issued read eventually needs a FIFO slot, so outstanding reads plus
  // buffered rows never exceed the depth; the FIFO can therefore never overflow.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign w_credit   = w_inflight < {1'b0, DEPTH_C};
  assign w_req      = (r_state == S_ISSUE) && w_credit;
  assign w_req_fire = w_req && read_addr_ready_i;
  assign w_full     = (r_fifo_cnt == DEPTH_C);
  // Returns with nothing outstanding (e.g. late data after a reset) are dropped.
  assign w_push     = read_data_valid_i && !w_full && (r_outstanding != '0);
  assign w_pop      = (r_fifo_cnt != '0) && out_ready_i;

  assign cmd_ready_o       = (r_state == S_IDLE);
  assign read_data_ready_o = !w_full;
  assign read_bank_en_o    = w_req ? r_bank_en : '0;
  assign read_group_id_o   = w_req ? r_group : '0;
  assign read_addr_o       = w_req ? {ROW_PARA{r_addr}} : '0;
  assign out_valid_o       = (r_fifo_cnt != '0);
  assign out_data_o        = out_valid_o ? r_mem[r_rd_ptr] : '0;
  assign out_last_o        = out_valid_o && (r_recv_cnt == LEN_WIDTH'(1));
  assign done_o            = (r_state == S_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_group     <= '0;
      r_bank_en   <= '0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      if (w_pop) r_recv_cnt <= r_recv_cnt - LEN_WIDTH'(1);
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if ((cmd_len_i != '0) && (cmd_bank_en_i != '0)) begin
              r_group     <= cmd_group_id_i;
              r_bank_en   <= cmd_bank_en_i;
              r_addr      <= cmd_base_addr_i;
              r_issue_cnt <= cmd_len_i;
              r_recv_cnt  <= cmd_len_i;
              r_state     <= S_ISSUE;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_ISSUE: begin
          if (w_req_fire) begin
            r_addr      <= r_addr + BANK_ADDR_WIDTH'(1);
            r_issue_cnt <= r_issue_cnt - LEN_WIDTH'(1);
            if (r_issue_cnt == LEN_WIDTH'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && (r_recv_cnt == LEN_WIDTH'(1))) r_state <= S_FIN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      if (w_req_fire && !w_push)      r_outstanding <= r_outstanding + CNT_W'(1);
      else if (!w_req_fire && w_push) r_outstanding <= r_outstanding - CNT_W'(1);
      if (w_push && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: a slot is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= read_data_i;
  end

endmodule

// File: tb/tb_save_read_engine.sv
// tb/tb_save_read_engine.sv - self-checking bench for save_read_engine
module tb_save_read_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid_i = 1'b0;
  logic         cmd_ready_o;
  logic [2:0]   cmd_group_id_i = '0;
  logic [3:0]   cmd_bank_en_i = '0;
  logic [11:0]  cmd_base_addr_i = '0;
  logic [11:0]  cmd_len_i = '0;
  logic [2:0]   read_group_id_o;
  logic [3:0]   read_bank_en_o;
  logic [47:0]  read_addr_o;
  logic         read_addr_ready_i = 1'b1;
  logic         read_data_valid_i = 1'b0;
  logic [255:0] read_data_i = '0;
  logic         read_data_ready_o;
  logic         out_valid_o;
  logic [255:0] out_data_o;
  logic         out_last_o;
  logic         out_ready_i = 1'b1;
  logic         done_o;

  always #5 clk = ~clk;

  save_read_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_group_id_i(cmd_group_id_i), .cmd_bank_en_i(cmd_bank_en_i),
    .cmd_base_addr_i(cmd_base_addr_i), .cmd_len_i(cmd_len_i),
    .read_group_id_o(read_group_id_o), .read_bank_en_o(read_bank_en_o),
    .read_addr_o(read_addr_o), .read_addr_ready_i(read_addr_ready_i),
    .read_data_valid_i(read_data_valid_i), .read_data_i(read_data_i),
    .read_data_ready_o(read_data_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .done_o(done_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pool row contents: the address and a per-burst tag, repeated in every 32-bit lane.
  function automatic logic [255:0] row(input logic [11:0] a, input logic [7:0] b);
    return {8{b, 8'h5A, 4'h0, a}};
  endfunction

  // Pool model: fixed one-cycle return latency; can be muted, and can inject stray rows.
  logic [7:0] burst_id = '0;
  logic       pool_en = 1'b1;
  int         stray_req = 0;
  int         stray_done = 0;

  initial begin
    logic        fire;
    logic [11:0] a;
    forever begin
      @(negedge clk);
      fire = rst_n && (read_bank_en_o != '0) && read_addr_ready_i;
      a = read_addr_o[11:0];
      @(posedge clk);
      #1;
      if (fire && pool_en) begin
        read_data_valid_i = 1'b1;
        read_data_i = row(a, burst_id);
      end else if (stray_done < stray_req) begin
        read_data_valid_i = 1'b1;
        read_data_i = row(12'hBAD, 8'hEE);
        stray_done++;
      end else begin
        read_data_valid_i = 1'b0;
        read_data_i = '0;
      end
    end
  end

  // Behavioural model: a burst is len words at base, base+1, ... (mod 4096); at most
  // 4 words may be requested but not yet streamed; rows leave in request order.
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_len = 0, m_issued = 0, m_recv = 0, m_popped = 0, m_done_cyc = -1;
  logic [11:0] m_base = '0;
  logic [3:0]  m_mask = '0;
  logic [2:0]  m_grp = '0;
  logic [7:0]  m_bid = '0;
  logic [11:0] req_log[$];
  logic [11:0] out_log[$];
  int          done_cnt = 0;

  initial begin
    bit          req_exp, oval_exp;
    int          outstanding;
    logic [11:0] ea;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_len = 0; m_issued = 0; m_recv = 0; m_popped = 0; m_done_cyc = -1;
        chk("rst_cmd_ready", cmd_ready_o, 1'b1);
        chk("rst_rd_ready", read_data_ready_o, 1'b1);
        chk("rst_bank_en", read_bank_en_o, 4'h0);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
      end else begin
        outstanding = m_issued - m_recv;
        chk("cmd_ready", cmd_ready_o, !m_busy);
        chk("done", done_o, cyc == m_done_cyc);
        if (done_o) done_cnt++;
        req_exp = m_busy && (m_issued < m_len) && ((m_issued - m_popped) < 4);
        chk("req_present", read_bank_en_o != '0, req_exp);
        if (req_exp && read_bank_en_o != '0) begin
          ea = m_base + 12'(m_issued);
          chk("req_mask", read_bank_en_o, m_mask);
          chk("req_group", read_group_id_o, m_grp);
          chk("req_addr", read_addr_o, {4{ea}});
          if (read_addr_ready_i) begin
            req_log.push_back(read_addr_o[11:0]);
            m_issued++;
          end
        end
        oval_exp = m_recv > m_popped;
        chk("out_valid", out_valid_o, oval_exp);
        if (oval_exp && out_valid_o) begin
          ea = m_base + 12'(m_popped);
          chk("out_data", out_data_o, row(ea, m_bid));
          chk("out_last", out_last_o, m_popped == m_len - 1);
          if (out_ready_i) begin
            out_log.push_back(out_data_o[11:0]);
            m_popped++;
            if (m_popped == m_len) m_done_cyc = cyc + 1;
          end
        end
        if (read_data_valid_i && outstanding > 0) begin
          chk("rd_ready", read_data_ready_o, 1'b1);
          m_recv++;
        end
        if (m_busy && cyc == m_done_cyc) m_busy = 0;
        else if (!m_busy && cmd_valid_i) begin
          m_busy = 1; m_issued = 0; m_recv = 0; m_popped = 0;
          m_base = cmd_base_addr_i; m_mask = cmd_bank_en_i; m_grp = cmd_group_id_i;
          m_bid = burst_id;
          if (cmd_len_i == '0 || cmd_bank_en_i == '0) begin
            m_len = 0;
            m_done_cyc = cyc + 1;
          end else begin
            m_len = int'(cmd_len_i);
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] g, input logic [3:0] m, input logic [11:0] b,
                      input logic [11:0] l);
    bit acc = 0;
    burst_id = burst_id + 8'd1;
    cmd_group_id_i = g; cmd_bank_en_i = m; cmd_base_addr_i = b; cmd_len_i = l;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin acc = 1; break; end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    chk("cmd_accepted", acc, 1'b1);
  endtask

  task automatic wait_done(input int max);
    bit ok = 0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      if (!m_busy) begin ok = 1; break; end
    end
    #1;
    chk("burst_complete", ok, 1'b1);
  endtask

  task automatic clear_logs();
    req_log.delete();
    out_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [3:0]  pat;
    logic [11:0] exp_a;
    pat = 4'b1001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_addr", read_addr_o, 48'h0);
    chk("reset_out_data", out_data_o, 256'h0);
    chk("reset_last", out_last_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: basic three-word burst
    clear_logs();
    send(3'b010, 4'b1111, 12'h010, 12'd3);
    wait_done(100);
    chk("t1_req_cnt", req_log.size(), 3);
    if (req_log.size() == 3) begin
      chk("t1_a0", req_log[0], 12'h010);
      chk("t1_a1", req_log[1], 12'h011);
      chk("t1_a2", req_log[2], 12'h012);
    end
    chk("t1_out_cnt", out_log.size(), 3);
    chk("t1_done_cnt", done_cnt, 1);

    // 2: address wrap
    clear_logs();
    send(3'b001, 4'b1111, 12'hFFE, 12'd4);
    wait_done(100);
    chk("t2_req_cnt", req_log.size(), 4);
    if (req_log.size() == 4) begin
      chk("t2_a0", req_log[0], 12'hFFE);
      chk("t2_a1", req_log[1], 12'hFFF);
      chk("t2_a2", req_log[2], 12'h000);
      chk("t2_a3", req_log[3], 12'h001);
    end
    if (out_log.size() == 4) chk("t2_out3", out_log[3], 12'h001);
    else chk("t2_out_cnt", out_log.size(), 4);

    // 3: downstream stall limits requests to the FIFO depth
    clear_logs();
    out_ready_i = 1'b0;
    send(3'b100, 4'b0011, 12'h100, 12'd10);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_stalled_reqs", req_log.size(), 4);
    chk("t3_stalled_outs", out_log.size(), 0);
    out_ready_i = 1'b1;
    wait_done(200);
    chk("t3_req_cnt", req_log.size(), 10);
    chk("t3_out_cnt", out_log.size(), 10);
    if (out_log.size() == 10) chk("t3_out9", out_log[9], 12'h109);

    // 4: request backpressure 1,0,0,1
    clear_logs();
    send(3'b010, 4'b1010, 12'h200, 12'd5);
    for (int i = 0; i < 100 && m_busy; i++) begin
      read_addr_ready_i = pat[i % 4];
      @(posedge clk);
      #1;
    end
    read_addr_ready_i = 1'b1;
    wait_done(50);
    chk("t4_req_cnt", req_log.size(), 5);
    for (int i = 0; i < 5 && i < req_log.size(); i++) begin
      exp_a = 12'h200 + 12'(i);
      chk("t4_addr", req_log[i], exp_a);
    end

    // 5: empty bursts
    clear_logs();
    send(3'b001, 4'b1111, 12'h300, 12'd0);
    wait_done(20);
    send(3'b001, 4'b0000, 12'h300, 12'd5);
    wait_done(20);
    chk("t5_req_cnt", req_log.size(), 0);
    chk("t5_done_cnt", done_cnt, 2);
    @(negedge clk);
    chk("t5_cmd_ready", cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // 6: reset with reads outstanding, then stray returns
    clear_logs();
    pool_en = 1'b0;
    out_ready_i = 1'b0;
    send(3'b100, 4'b1111, 12'h400, 12'd6);
    for (int i = 0; i < 50 && req_log.size() < 2; i++) @(posedge clk);
    #1;
    chk("t6_two_reqs", req_log.size(), 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_bank_en", read_bank_en_o, 4'h0);
    chk("t6_rst_cmd_ready", cmd_ready_o, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pool_en = 1'b1;
    out_ready_i = 1'b1;
    stray_req = 2;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_stray_out", out_log.size(), 0);
    clear_logs();
    send(3'b100, 4'b0101, 12'h050, 12'd2);
    wait_done(50);
    chk("t6_req_cnt", req_log.size(), 2);
    if (req_log.size() == 2) chk("t6_a1", req_log[1], 12'h051);
    chk("t6_out_cnt", out_log.size(), 2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
